// File: rtl/trace_tty_monitor.sv
// Commit-trace checker plus UART console receiver with optional echo.
// Counts retirements and traps for one hart and raises a sticky finish on the end-of-test encoding.
module trace_tty_monitor #(
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ECHO        = 0,
  parameter int unsigned CLK_FREQ_HZ = 11520000,
  parameter logic [63:0] HART_ID     = 64'd0,
  parameter logic [31:0] FINISH_INST = 32'h0000006F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [63:0] hartid,
  input  logic [63:0] pc,
  input  logic [31:0] inst,
  input  logic [63:0] wdata,
  input  logic [6:0]  mstatus,
  input  logic        int_xcpt,
  input  logic [63:0] cause,
  output logic        finish,
  output logic [63:0] commit_count,
  output logic [63:0] last_pc,
  output logic [31:0] trap_count,
  input  logic        srx,
  output logic        stx,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned FULL_M1      = CLKS_PER_BIT - 1;
  localparam int unsigned HALF_M1      = CLKS_PER_BIT / 2 - 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // ---------------- commit trace ----------------
  logic        finish_q, finish_d;
  logic [63:0] commit_count_q, commit_count_d;
  logic [63:0] last_pc_q, last_pc_d;
  logic [31:0] trap_count_q, trap_count_d;
  logic [63:0] wdata_q, wdata_d;
  logic [6:0]  mstatus_q, mstatus_d;
  logic [63:0] cause_q, cause_d;
  logic        commit_qual_c;

  assign commit_qual_c = valid && (hartid == HART_ID);

  always_comb begin
    finish_d       = finish_q;
    commit_count_d = commit_count_q;
    last_pc_d      = last_pc_q;
    trap_count_d   = trap_count_q;
    wdata_d        = wdata_q;
    mstatus_d      = mstatus_q;
    cause_d        = cause_q;
    if (commit_qual_c) begin
      if (int_xcpt) begin
        trap_count_d = trap_count_q + 32'd1;
        cause_d      = cause;
      end else begin
        commit_count_d = commit_count_q + 64'd1;
        last_pc_d      = pc;
        wdata_d        = wdata;
        mstatus_d      = mstatus;
        if (inst == FINISH_INST) finish_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      finish_q       <= 1'b0;
      commit_count_q <= '0;
      last_pc_q      <= '0;
      trap_count_q   <= '0;
      wdata_q        <= '0;
      mstatus_q      <= '0;
      cause_q        <= '0;
    end else begin
      finish_q       <= finish_d;
      commit_count_q <= commit_count_d;
      last_pc_q      <= last_pc_d;
      trap_count_q   <= trap_count_d;
      wdata_q        <= wdata_d;
      mstatus_q      <= mstatus_d;
      cause_q        <= cause_d;
    end
  end

  // Recorded trace fields are kept for waveform inspection only.
  logic unused_trace;
  assign unused_trace = ^{wdata_q, mstatus_q, cause_q};

  // ---------------- UART receive ----------------
  rx_state_e          rx_state_q, rx_state_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_err_q, rx_err_d;
  logic               sync1_q, sync2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!sync2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == CNT_W'(HALF_M1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = 3'd0;
        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == CNT_W'(FULL_M1)) begin
        rx_cnt_d   = '0;
        rx_shift_d = {sync2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == CNT_W'(FULL_M1)) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        if (sync2_q) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
        end else begin
          rx_err_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      sync1_q    <= srx;
      sync2_q    <= sync1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // ---------------- UART echo transmit ----------------
  // The one-entry buffer is only ever filled when echo is enabled, so stx rests high otherwise.
  tx_state_e          tx_state_q, tx_state_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]         tx_bit_q, tx_bit_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic [7:0]         buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               stx_q, stx_d;
  logic               load_c;
  logic               take_c;

  assign load_c = (ECHO != 0) && rx_valid_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    take_c     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (buf_full_q) begin
          take_c     = 1'b1;
          tx_shift_d = buf_q;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == CNT_W'(FULL_M1)) begin
        tx_cnt_d   = '0;
        tx_bit_d   = 3'd0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == CNT_W'(FULL_M1)) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == CNT_W'(FULL_M1)) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    buf_d      = load_c ? rx_data_q : buf_q;
    buf_full_d = load_c ? 1'b1 : (take_c ? 1'b0 : buf_full_q);
    unique case (tx_state_d)
      TX_START: stx_d = 1'b0;
      TX_DATA:  stx_d = tx_shift_d[0];
      default:  stx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      stx_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      stx_q      <= stx_d;
    end
  end

  assign finish       = finish_q;
  assign commit_count = commit_count_q;
  assign last_pc      = last_pc_q;
  assign trap_count   = trap_count_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_frame_err = rx_err_q;
  assign stx          = stx_q;

endmodule

// File: tb/tb_trace_tty_monitor.sv
// Bench for trace_tty_monitor: directed commit vectors plus UART frames checked through byte scoreboards.
module tb_trace_tty_monitor;

  localparam int CPB = 100;

  logic        clk, rst, valid, int_xcpt, srx;
  logic [63:0] hartid, pc, wdata, cause;
  logic [31:0] inst;
  logic [6:0]  mstatus;
  logic        finish, stx, rx_valid, rx_frame_err;
  logic [63:0] commit_count, last_pc;
  logic [31:0] trap_count;
  logic [7:0]  rx_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  trace_tty_monitor #(.BAUD(115200), .ECHO(1), .CLK_FREQ_HZ(11520000),
                      .HART_ID(64'd0), .FINISH_INST(32'h0000006F)) dut (
    .clock(clk), .reset(rst), .valid(valid), .hartid(hartid), .pc(pc), .inst(inst),
    .wdata(wdata), .mstatus(mstatus), .int_xcpt(int_xcpt), .cause(cause),
    .finish(finish), .commit_count(commit_count), .last_pc(last_pc),
    .trap_count(trap_count), .srx(srx), .stx(stx), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_frame_err(rx_frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_commit(input logic [63:0] h, input logic [63:0] p, input logic [31:0] i,
                           input logic x, input logic [63:0] c);
    @(negedge clk);
    valid = 1'b1; hartid = h; pc = p; inst = i; int_xcpt = x; cause = c;
    wdata = p ^ 64'h5555; mstatus = 7'h2A;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    @(negedge clk);
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      srx = fr[i];
      repeat (CPB) @(negedge clk);
    end
    srx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Receive-side scoreboard: every rx_valid pulse must match the oldest expected byte.
  initial begin : rx_mon
    logic       prev;
    logic [7:0] e;
    int         lat;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (rx_valid) begin
          check("rx_valid_single_cycle", 64'(prev), 64'd0);
          if (rx_exp.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rx_unexpected: got byte %h expected no byte", rx_data);
          end else begin
            e = rx_exp.pop_front();
            check("rx_data", 64'(rx_data), 64'(e));
            lat = cyc - start_cyc;
            n_cmp++;
            if (lat < 940 || lat > 965) begin
              n_err++;
              $display("FAIL rx_latency: got %0d cycles expected 940..965", lat);
            end
          end
        end
        prev = rx_valid;
      end
    end
  end

  // Echo scoreboard: decode frames appearing on stx at mid-bit.
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && stx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", 64'(stx), 64'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = stx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", 64'(stx), 64'd1);
        if (tx_exp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_unexpected: got byte %h expected no byte", b);
        end else begin
          e = tx_exp.pop_front();
          check("tx_echo_byte", 64'(b), 64'(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; srx = 1'b1; valid = 1'b0; int_xcpt = 1'b0;
    hartid = '0; pc = '0; inst = '0; wdata = '0; cause = '0; mstatus = '0;
    repeat (5) @(negedge clk);
    check("reset_finish", 64'(finish), 64'd0);
    check("reset_stx", 64'(stx), 64'd1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_finish", 64'(finish), 64'd0);
    check("idle_commit_count", commit_count, 64'd0);
    check("idle_last_pc", last_pc, 64'd0);
    check("idle_trap_count", 64'(trap_count), 64'd0);
    check("idle_rx_data", 64'(rx_data), 64'd0);
    check("idle_frame_err", 64'(rx_frame_err), 64'd0);
    check("idle_stx", 64'(stx), 64'd1);

    for (int k = 0; k < 5; k++)
      do_commit(64'd0, 64'h80000000 + 64'(4 * k), 32'h00000013, 1'b0, 64'd0);
    check("five_commit_count", commit_count, 64'd5);
    check("five_last_pc", last_pc, 64'h80000010);
    check("five_finish", 64'(finish), 64'd0);

    do_commit(64'd0, 64'h80000200, 32'h00000013, 1'b1, 64'd7);
    do_commit(64'd1, 64'h90000000, 32'h0000006F, 1'b0, 64'd0);
    check("trap_count", 64'(trap_count), 64'd1);
    check("trap_commit_count", commit_count, 64'd5);
    check("trap_last_pc", last_pc, 64'h80000010);
    check("foreign_hart_finish", 64'(finish), 64'd0);

    @(negedge clk);
    valid = 1'b1; hartid = 64'd0; pc = 64'h80000100; inst = 32'h0000006F; int_xcpt = 1'b0;
    check("finish_before_edge", 64'(finish), 64'd0);
    @(negedge clk);
    valid = 1'b0;
    check("finish_next_cycle", 64'(finish), 64'd1);
    check("finish_commit_count", commit_count, 64'd6);
    check("finish_last_pc", last_pc, 64'h80000100);
    do_commit(64'd0, 64'h80000104, 32'h00000013, 1'b0, 64'd0);
    do_commit(64'd0, 64'h80000108, 32'h00000013, 1'b1, 64'd2);
    check("after_finish_sticky", 64'(finish), 64'd1);
    check("after_finish_count", commit_count, 64'd7);
    check("after_finish_last_pc", last_pc, 64'h80000104);
    check("after_finish_traps", 64'(trap_count), 64'd2);

    rx_exp.push_back(8'h41); tx_exp.push_back(8'h41);
    send_byte(8'h41, 1'b1);
    check("rx_data_hold_41", 64'(rx_data), 64'h41);

    @(negedge clk);
    srx = 1'b0;
    repeat (20) @(negedge clk);
    srx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_frame_err", 64'(rx_frame_err), 64'd0);
    check("glitch_rx_data", 64'(rx_data), 64'h41);

    rx_exp.push_back(8'h5A); tx_exp.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    check("frame_err_clear", 64'(rx_frame_err), 64'd0);

    send_byte(8'hC3, 1'b0);
    check("frame_err_set", 64'(rx_frame_err), 64'd1);
    check("frame_err_rx_data", 64'(rx_data), 64'h5A);
    repeat (1200) @(negedge clk);
    check("rx_queue_drained", 64'(rx_exp.size()), 64'd0);
    check("tx_queue_drained", 64'(tx_exp.size()), 64'd0);

    @(negedge clk);
    srx = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1; srx = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_finish", 64'(finish), 64'd0);
    check("midreset_count", commit_count, 64'd0);
    check("midreset_frame_err", 64'(rx_frame_err), 64'd0);
    check("midreset_stx", 64'(stx), 64'd1);
    rst = 1'b0;
    repeat (1200) @(negedge clk);
    check("midreset_rx_data", 64'(rx_data), 64'd0);

    rx_exp.push_back(8'h3C); tx_exp.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    repeat (1200) @(negedge clk);
    check("final_rx_queue", 64'(rx_exp.size()), 64'd0);
    check("final_tx_queue", 64'(tx_exp.size()), 64'd0);
    check("final_rx_data", 64'(rx_data), 64'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
